// File: rtl/program_loader_pkg.sv
// Shared definitions for the boot loader: state encoding and bus widths common with RISC_SPM.
// No logic; imported by program_loader and loader_checksum.
package program_loader_pkg;

    localparam int WORD_SIZE = 8;
    localparam int ADDR_SIZE = 8;

    typedef logic [2:0] state_t;

    localparam state_t ST_IDLE = 3'd0;
    localparam state_t ST_LEN  = 3'd1;
    localparam state_t ST_DATA = 3'd2;
    localparam state_t ST_CSUM = 3'd3;
    localparam state_t ST_DONE = 3'd4;
    localparam state_t ST_ERR  = 3'd5;

endpackage

// File: rtl/loader_checksum.sv
// Modular byte-sum accumulator with synchronous clear and add-enable; sum updates on the accepting edge.
// Compare output is combinational against i_cmp_data; no flow control of its own.
module loader_checksum
    import program_loader_pkg::*;
#(
    parameter int word_size = WORD_SIZE
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 i_clr,
    input  logic                 i_add_en,
    input  logic [word_size-1:0] i_data,
    input  logic [word_size-1:0] i_cmp_data,
    output logic                 o_match
);

    logic [word_size-1:0] r_sum;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_sum <= '0;
        end else if (i_clr) begin
            r_sum <= '0;
        end else if (i_add_en) begin
            r_sum <= r_sum + i_data;
        end
    end

    assign o_match = (r_sum == i_cmp_data);

endmodule

// File: rtl/program_loader.sv
// Boot loader: LEN / data / CSUM byte stream into memory, one-cycle write latency per accepted byte.
// in_ready high only while collecting a frame; the source may stall indefinitely with the CPU held.
module program_loader
    import program_loader_pkg::*;
#(
    parameter int word_size = WORD_SIZE,
    parameter int addr_size = ADDR_SIZE,
    parameter int BASE_ADDR = 0
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 in_valid,
    input  logic [word_size-1:0] in_data,
    output logic                 in_ready,
    output logic [addr_size-1:0] mem_address,
    output logic [word_size-1:0] mem_data_in,
    output logic                 mem_write,
    output logic                 cpu_hold,
    output logic                 done,
    output logic                 error
);

    localparam logic [addr_size-1:0] LP_BASE = addr_size'(BASE_ADDR);
    localparam logic [addr_size-1:0] LP_ONE  = addr_size'(1);

    state_t r_state;
    state_t w_next_state;

    logic [addr_size-1:0] r_len;
    logic [addr_size-1:0] r_idx;
    logic                 r_mem_write;
    logic [addr_size-1:0] r_mem_address;
    logic [word_size-1:0] r_mem_data_in;

    logic w_in_ready;
    logic w_accept;
    logic w_start_load;
    logic w_last;
    logic w_data_acc;
    logic w_csum_match;

    assign w_accept     = in_valid && w_in_ready;
    assign w_data_acc   = w_accept && (r_state == ST_DATA);
    // LEN of 0 encodes a full 2^addr_size image, which falls out of the modular compare.
    assign w_last       = (r_idx == (r_len - LP_ONE));
    assign w_start_load = start && ((r_state == ST_IDLE) || (r_state == ST_DONE) || (r_state == ST_ERR));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE, ST_DONE, ST_ERR: begin
                if (start) begin
                    w_next_state = ST_LEN;
                end
            end
            ST_LEN: begin
                if (w_accept) begin
                    w_next_state = ST_DATA;
                end
            end
            ST_DATA: begin
                if (w_accept && w_last) begin
                    w_next_state = ST_CSUM;
                end
            end
            ST_CSUM: begin
                if (w_accept) begin
                    w_next_state = w_csum_match ? ST_DONE : ST_ERR;
                end
            end
            default: begin
                w_next_state = ST_IDLE;
            end
        endcase
    end

    always_comb begin
        w_in_ready = 1'b0;
        cpu_hold   = 1'b1;
        done       = 1'b0;
        error      = 1'b0;
        case (r_state)
            ST_LEN, ST_DATA, ST_CSUM: begin
                w_in_ready = 1'b1;
            end
            ST_DONE: begin
                done     = 1'b1;
                cpu_hold = 1'b0;
            end
            ST_ERR: begin
                error = 1'b1;
            end
            default: begin
                w_in_ready = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_len <= '0;
            r_idx <= '0;
        end else begin
            if (w_start_load) begin
                r_idx <= '0;
            end else if (w_data_acc) begin
                r_idx <= r_idx + LP_ONE;
            end
            if (w_accept && (r_state == ST_LEN)) begin
                r_len <= addr_size'(in_data);
            end
        end
    end

    // Address and data hold their last values between strobes.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_mem_write   <= 1'b0;
            r_mem_address <= '0;
            r_mem_data_in <= '0;
        end else begin
            r_mem_write <= w_data_acc;
            if (w_data_acc) begin
                r_mem_address <= LP_BASE + r_idx;
                r_mem_data_in <= in_data;
            end
        end
    end

    loader_checksum #(
        .word_size (word_size)
    ) u_checksum (
        .clk        (clk),
        .rst        (rst),
        .i_clr      (w_start_load),
        .i_add_en   (w_data_acc),
        .i_data     (in_data),
        .i_cmp_data (in_data),
        .o_match    (w_csum_match)
    );

    assign in_ready    = w_in_ready;
    assign mem_write   = r_mem_write;
    assign mem_address = r_mem_address;
    assign mem_data_in = r_mem_data_in;

endmodule

// File: tb/tb_program_loader.sv
// Bench for program_loader: table of image loads against a byte-level reference model, plus reset/restart sequences.
module tb_program_loader;

    typedef struct {
        int   sel;
        int   n;
        int   kind;
        int   csum_off;
        int   vpat;
        int   start_at;
        logic exp_done;
        logic exp_err;
        logic exp_hold;
        logic exp_rdy;
    } vec_t;

    typedef struct {
        int         cyc;
        logic [7:0] a;
        logic [7:0] d;
    } wr_t;

    logic       clk;
    logic       rst;
    logic       start0;
    logic       start1;
    logic       in_valid;
    logic [7:0] in_data;

    logic       rdy0, wr0, hold0, done0, err0;
    logic [7:0] addr0, dat0;
    logic       rdy1, wr1, hold1, done1, err1;
    logic [7:0] addr1, dat1;

    logic       s_rdy, s_done, s_err, s_hold;

    int   sel;
    int   cyc;
    int   checks;
    int   errors;
    wr_t  qw0[$];
    wr_t  qw1[$];
    vec_t vecs[8];

    program_loader #(.word_size(8), .addr_size(8), .BASE_ADDR(0)) dut0 (
        .clk(clk), .rst(rst), .start(start0), .in_valid(in_valid), .in_data(in_data),
        .in_ready(rdy0), .mem_address(addr0), .mem_data_in(dat0), .mem_write(wr0),
        .cpu_hold(hold0), .done(done0), .error(err0)
    );

    program_loader #(.word_size(8), .addr_size(8), .BASE_ADDR(240)) dut1 (
        .clk(clk), .rst(rst), .start(start1), .in_valid(in_valid), .in_data(in_data),
        .in_ready(rdy1), .mem_address(addr1), .mem_data_in(dat1), .mem_write(wr1),
        .cpu_hold(hold1), .done(done1), .error(err1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (wr0) qw0.push_back('{cyc, addr0, dat0});
        if (wr1) qw1.push_back('{cyc, addr1, dat1});
    end

    always_comb begin
        if (sel == 0) begin
            s_rdy = rdy0; s_done = done0; s_err = err0; s_hold = hold0;
        end else begin
            s_rdy = rdy1; s_done = done1; s_err = err1; s_hold = hold1;
        end
    end

    task automatic chk(input bit ok, input string nm, input longint act, input longint exp);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    task automatic pulse_start(input int which);
        if (which == 0) start0 = 1'b1;
        else            start1 = 1'b1;
    endtask

    // Streams one image; the model is simply "byte k lands at base+k one edge after it is taken".
    task automatic run_image(input vec_t v, input string nm);
        logic [7:0] img[$];
        int         exp_edge[$];
        wr_t        q[$];
        wr_t        oq[$];
        logic [7:0] b;
        logic [7:0] sum;
        int         n, base, idx, cnt, lim;
        bit         ok;

        sel  = v.sel;
        base = (v.sel == 0) ? 0 : 240;
        n    = (v.n < 0) ? int'($urandom_range(1, 40)) : v.n;
        sum  = 8'h00;
        img.push_back(8'(n));
        for (int k = 0; k < n; k++) begin
            case (v.kind)
                0:       b = 8'hA1 + 8'(k) * 8'h11;
                1:       b = 8'h01;
                default: b = 8'($urandom);
            endcase
            img.push_back(b);
            sum = sum + b;
        end
        img.push_back(sum + 8'(v.csum_off));
        qw0.delete();
        qw1.delete();

        pulse_start(v.sel);
        @(posedge clk); #1;
        start0 = 1'b0; start1 = 1'b0;

        idx = 0;
        cnt = 0;
        while (idx < img.size() && cnt < 3000) begin
            case (v.vpat)
                0:       in_valid = 1'b1;
                1:       in_valid = (cnt % 3 == 0);
                default: in_valid = 1'($urandom_range(0, 1));
            endcase
            in_data = in_valid ? img[idx] : 8'($urandom);
            if (v.start_at > 0 && idx == v.start_at) pulse_start(v.sel);
            @(negedge clk);
            if (in_valid && s_rdy) begin
                if (idx >= 1 && idx <= n) exp_edge.push_back(cyc + 1);
                idx++;
            end
            @(posedge clk); #1;
            start0 = 1'b0; start1 = 1'b0;
            cnt++;
        end
        in_valid = 1'b0;
        chk(idx == img.size(), {nm, "_stream_timeout"}, idx, img.size());

        @(negedge clk);
        chk(s_done == v.exp_done, {nm, "_done"}, s_done, v.exp_done);
        chk(s_err  == v.exp_err,  {nm, "_error"}, s_err, v.exp_err);
        chk(s_hold == v.exp_hold, {nm, "_cpu_hold"}, s_hold, v.exp_hold);
        chk(s_rdy  == v.exp_rdy,  {nm, "_in_ready"}, s_rdy, v.exp_rdy);

        repeat (3) @(posedge clk);
        #1;
        if (sel == 0) begin q = qw0; oq = qw1; end
        else          begin q = qw1; oq = qw0; end
        chk(q.size() == n, {nm, "_write_count"}, q.size(), n);
        chk(oq.size() == 0, {nm, "_idle_dut_writes"}, oq.size(), 0);
        lim = (q.size() < exp_edge.size()) ? q.size() : exp_edge.size();
        for (int k = 0; k < lim && k < n; k++) begin
            ok = (q[k].a == 8'(base + k)) && (q[k].d == img[k + 1]) && (q[k].cyc == exp_edge[k]);
            chk(ok, $sformatf("%s_write%0d(cyc,addr,data)", nm, k),
                {32'(q[k].cyc), 8'h00, q[k].a, q[k].d},
                {32'(exp_edge[k]), 8'h00, 8'(base + k), img[k + 1]});
        end
    endtask

    initial begin
        checks   = 0;
        errors   = 0;
        sel      = 0;
        rst      = 1'b0;
        start0   = 1'b0;
        start1   = 1'b0;
        in_valid = 1'b0;
        in_data  = 8'h00;

        //                sel  n    kind off vpat st  done err hold rdy
        vecs[0] = '{0,   3,   0,   0,  0,   0,  1'b1, 1'b0, 1'b0, 1'b0};
        vecs[1] = '{0,   3,   0,   1,  0,   0,  1'b0, 1'b1, 1'b1, 1'b0};
        vecs[2] = '{0,   3,   0,   0,  1,   0,  1'b1, 1'b0, 1'b0, 1'b0};
        vecs[3] = '{1,   256, 1,   0,  0,   0,  1'b1, 1'b0, 1'b0, 1'b0};
        vecs[4] = '{0,   3,   0,   0,  0,   2,  1'b1, 1'b0, 1'b0, 1'b0};
        vecs[5] = '{0,   -1,  2,   0,  2,   0,  1'b1, 1'b0, 1'b0, 1'b0};
        vecs[6] = '{0,   -1,  2,   90, 2,   0,  1'b0, 1'b1, 1'b1, 1'b0};
        vecs[7] = '{1,   -1,  2,   0,  2,   0,  1'b1, 1'b0, 1'b0, 1'b0};

        #1;
        chk(rdy0 == 1'b0,   "rst_in_ready0", rdy0, 0);
        chk(wr0 == 1'b0,    "rst_mem_write0", wr0, 0);
        chk(addr0 == 8'h00, "rst_mem_address0", addr0, 0);
        chk(dat0 == 8'h00,  "rst_mem_data0", dat0, 0);
        chk(hold0 == 1'b1,  "rst_cpu_hold0", hold0, 1);
        chk(done0 == 1'b0,  "rst_done0", done0, 0);
        chk(err0 == 1'b0,   "rst_error0", err0, 0);
        chk(rdy1 == 1'b0 && wr1 == 1'b0 && hold1 == 1'b1 && done1 == 1'b0 && err1 == 1'b0,
            "rst_flags1", {rdy1, wr1, hold1, done1, err1}, 5'b00100);
        @(posedge clk); #1;
        rst = 1'b1;

        for (int i = 0; i < 8; i++) begin
            run_image(vecs[i], $sformatf("v%0d", i));
        end

        // Reset lands while the second data byte's write is on the bus.
        sel = 0;
        start0 = 1'b1;
        @(posedge clk); #1;
        start0 = 1'b0;
        in_valid = 1'b1; in_data = 8'h03;
        @(posedge clk); #1;
        in_data = 8'hA1;
        @(posedge clk); #1;
        in_data = 8'hB2;
        @(posedge clk); #2;
        chk(wr0 == 1'b1 && addr0 == 8'h01, "pre_reset_write", {wr0, addr0}, 9'h101);
        rst = 1'b0;
        #1;
        chk(rdy0 == 1'b0,   "midrst_in_ready", rdy0, 0);
        chk(wr0 == 1'b0,    "midrst_mem_write", wr0, 0);
        chk(addr0 == 8'h00, "midrst_mem_address", addr0, 0);
        chk(dat0 == 8'h00,  "midrst_mem_data", dat0, 0);
        chk(hold0 == 1'b1 && done0 == 1'b0 && err0 == 1'b0, "midrst_flags",
            {hold0, done0, err0}, 3'b100);
        in_valid = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        run_image(vecs[0], "after_reset");

        // Restart from DONE: flags fall on the same edge that enters LEN.
        start0 = 1'b1;
        @(posedge clk); #1;
        start0 = 1'b0;
        @(negedge clk);
        chk(done0 == 1'b0, "restart_done", done0, 0);
        chk(hold0 == 1'b1, "restart_cpu_hold", hold0, 1);
        chk(rdy0 == 1'b1,  "restart_in_ready", rdy0, 1);
        @(posedge clk); #1;
        run_image(vecs[2], "after_restart");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/program_loader.md
Name: program_loader

Overview:
Boot-time loader that sits upstream of the RISC_SPM memory (Memory_Unit). It receives a program image as a byte stream over a valid/ready handshake and writes it into memory through the memory's write port (address, data_in, write). While loading, it holds the processor and control unit in reset, then releases them only after the image checksum matches. The top level muxes the memory address, data and write lines between the loader and the processor, using cpu_hold as the select.

Parameters:
word_size, 8, width of data bytes, the checksum and the length field
addr_size, 8, width of the memory address
BASE_ADDR, 0, first memory address written; later addresses wrap modulo 2^addr_size

Ports:
clk  input  1  system clock; all state changes on the rising edge
rst  input  1  asynchronous, active-low reset (0 = reset); asserts immediately, deasserts synchronously to clk by the top level
start  input  1  single-cycle request to begin a load
in_valid  input  1  source has a byte on in_data
in_data  input  word_size  stream byte
in_ready  output  1  loader accepts a byte this cycle
mem_address  output  addr_size  memory write address
mem_data_in  output  word_size  memory write data
mem_write  output  1  memory write strobe, one cycle per byte
cpu_hold  output  1  1 = keep the processor in reset and the loader owns the memory bus
done  output  1  load completed and checksum OK (sticky)
error  output  1  checksum mismatch (sticky)

Behaviour:
- Reset values (rst=0, asynchronous):
  - state = IDLE
  - in_ready=0, mem_write=0, mem_address=0, mem_data_in=0
  - cpu_hold=1, done=0, error=0
  - byte counter and checksum accumulator = 0
- Transfer rule: a byte is accepted on a rising edge where in_valid && in_ready. in_data is ignored otherwise. in_valid may go low between bytes with no penalty.
- Image format, in stream order:
  - LEN byte: count N of data bytes; N=0 means 2^addr_size bytes.
  - N data bytes.
  - CSUM byte: sum of the data bytes modulo 2^word_size. The LEN byte is not included in the sum.
- States:
  - IDLE: in_ready=0. start=1 -> LEN, clearing the counter and checksum. cpu_hold stays 1.
  - LEN: in_ready=1. An accepted byte latches N -> DATA.
  - DATA: in_ready=1, throughput up to one byte per cycle. Each accepted byte k (k=0..N-1) has fixed write latency 1: on the next cycle mem_write=1, mem_address=BASE_ADDR+k (mod 2^addr_size), mem_data_in=byte, checksum += byte (mod 2^word_size). Accepting byte N-1 -> CSUM.
  - CSUM: in_ready=1. The final data write is still completing during the first cycle in this state. On an accepted byte: equal to the checksum -> DONE, else -> ERR.
  - DONE: done=1, cpu_hold=0, in_ready=0.
  - ERR: error=1, cpu_hold=1, in_ready=0.
- mem_write is low in every cycle except the write cycles above. mem_address and mem_data_in hold their last values when mem_write=0.
- start is honoured only in IDLE, DONE and ERR. From DONE or ERR, start -> LEN: it clears done and error and sets cpu_hold=1 in the same edge. start is ignored in LEN, DATA and CSUM.
- Address wrap: BASE_ADDR+k past 2^addr_size-1 wraps to 0 without error.
- Reset mid-load: aborts immediately. Memory keeps whatever was already written. The next start reloads from BASE_ADDR.
- No timeout. A stalled source leaves the loader waiting indefinitely with cpu_hold=1.

Decomposition:
- Shared package holds:
  - state encoding localparams (IDLE, LEN, DATA, CSUM, DONE, ERR; 3-bit)
  - word_size and addr_size defaults shared with RISC_SPM
- One sub-module, loader_checksum: word_size accumulator with clear and add-enable, plus a compare output.
- The FSM, the counter and the write register stay in program_loader.

Test Plan:
- Basic load: start, then bytes 03, A1, B2, C3, 16 with in_valid held high. Required: writes (00,A1), (01,B2), (02,C3) on consecutive cycles; then done=1, cpu_hold=0, error=0.
- Bad checksum: same image with CSUM=17. Required: the three writes still occur; error=1, done=0, cpu_hold=1, in_ready=0.
- Backpressure: same image with in_valid toggling 1,0,0,1,... Required: exactly one mem_write per accepted data byte; addresses contiguous 00..02; no writes in idle gaps.
- Full wrap: BASE_ADDR=F0, LEN=00, 256 data bytes of value 01, CSUM=00. Required: writes F0..FF then 00..EF; done=1.
- Reset mid-DATA: drop rst after 2 of 3 data bytes. Required: all outputs return to reset values without waiting for a clock edge. A new start plus a full image then loads from BASE_ADDR and sets done.
- Restart: in DONE, pulse start. Required: done=0 and cpu_hold=1 the next cycle; start pulsed during DATA has no effect.
